// File: rtl/imm_pkg.sv
// Shared RISC-V opcode constants, immediate format codes and the datapath
// width legality check for the immediate decode pipeline.
package imm_pkg;

    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational instruction format detection and immediate extraction,
// producing an XLEN-wide sign- or zero-extended immediate.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] raw32;
    fmt_e        fmt;

    always_comb begin
        opcode = instr_i[6:0];
        funct3 = instr_i[14:12];
        fmt    = FMT_ILL;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: fmt = FMT_I;
            OP_STORE:         fmt = FMT_S;
            OP_BRANCH:        fmt = FMT_B;
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            OP_OP:            fmt = FMT_R;
            OP_OP_32:         fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
            OP_IMM_32:        fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
            default:          fmt = FMT_ILL;
        endcase

        // Every format is built as a 32-bit value already sign-extended from bit 31
        raw32 = '0;
        case (fmt)
            FMT_I: raw32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: raw32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: raw32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: raw32 = {instr_i[31:12], 12'h000};
            FMT_J: raw32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: raw32 = '0;
        endcase

        imm_o = XLEN'($signed(raw32));
        // Immediate shifts carry only the shift amount; funct7 bits are dropped
        if ((opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101))) begin
            imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
        end

        fmt_o     = fmt;
        illegal_o = (fmt == FMT_ILL);
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// Immediate decoder followed by a 2-entry FIFO: one cycle of latency, no
// combinational input-to-output path, tag carried alongside each entry.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]  imm_q [2];
    fmt_e             fmt_q [2];
    logic             ill_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2) | ~rst_n;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload needs no reset: outputs are masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            imm_q[wr_ptr_q] <= dec_imm;
            fmt_q[wr_ptr_q] <= dec_fmt;
            ill_q[wr_ptr_q] <= dec_illegal;
            tag_q[wr_ptr_q] <= in_tag;
        end
    end

    assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_fmt     = out_valid ? fmt_q[rd_ptr_q] : FMT_R;
    assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;
    assign out_tag     = out_valid ? tag_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe: XLEN=32 and XLEN=64 instances share
// stimulus; each scenario task checks its own expected values inline.
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [15:0] in_tag;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [15:0] out_tag32;

    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [15:0] out_tag64;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_decode_pipe #(.XLEN(32), .TAG_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_ill32), .out_tag(out_tag32)
    );

    imm_decode_pipe #(.XLEN(64), .TAG_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_ill64), .out_tag(out_tag64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
    } vec_t;

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_instr = 32'hFFF00093; in_tag = 16'hABCD;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL rst_valid32: got %b want 0", out_valid32); end
        n_cmp++; if (out_imm32 !== 32'h0) begin n_err++; $display("FAIL rst_imm32: got %h want 0", out_imm32); end
        n_cmp++; if (out_fmt32 !== 3'd0) begin n_err++; $display("FAIL rst_fmt32: got %0d want 0", out_fmt32); end
        n_cmp++; if (out_ill32 !== 1'b0) begin n_err++; $display("FAIL rst_ill32: got %b want 0", out_ill32); end
        n_cmp++; if (out_tag32 !== 16'h0) begin n_err++; $display("FAIL rst_tag32: got %h want 0", out_tag32); end
        n_cmp++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL rst_ready32: got %b want 1", in_ready32); end
        n_cmp++; if (out_imm64 !== 64'h0) begin n_err++; $display("FAIL rst_imm64: got %h want 0", out_imm64); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL rst_discard: got %b want 0", out_valid32); end
    endtask

    task automatic test_decode();
        vec_t vecs[$];
        vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1});
        vecs.push_back('{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2});
        vecs.push_back('{32'hFE209CE3, 32'hFFFFFFF8, 3'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3});
        vecs.push_back('{32'h123452B7, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4});
        vecs.push_back('{32'h00309093, 32'h00000003, 3'd1, 64'h3, 3'd1});
        vecs.push_back('{32'h4050D093, 32'h00000005, 3'd1, 64'h5, 3'd1});
        vecs.push_back('{32'h0000007F, 32'h00000000, 3'd7, 64'h0, 3'd7});
        vecs.push_back('{32'h002081B3, 32'h00000000, 3'd0, 64'h0, 3'd0});
        vecs.push_back('{32'h008000EF, 32'h00000008, 3'd5, 64'h8, 3'd5});
        vecs.push_back('{32'h0000003B, 32'h00000000, 3'd7, 64'h0, 3'd0});
        vecs.push_back('{32'h800002B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4});
        vecs.push_back('{32'h4250D093, 32'h00000005, 3'd1, 64'h25, 3'd1});
        vecs.push_back('{32'h0010009B, 32'h00000000, 3'd7, 64'h1, 3'd1});
        vecs.push_back('{32'h0000000F, 32'h00000000, 3'd1, 64'h0, 3'd1});
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            in_instr = vecs[i].instr; in_tag = 16'(i + 100);
            n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL dec%0d_bypass: got %b want 0", i, out_valid32); end
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_cmp++; if (out_valid32 !== 1'b1) begin n_err++; $display("FAIL dec%0d_valid32: got %b want 1", i, out_valid32); end
            n_cmp++; if (out_imm32 !== vecs[i].imm32) begin n_err++; $display("FAIL dec%0d_imm32: got %h want %h", i, out_imm32, vecs[i].imm32); end
            n_cmp++; if (out_fmt32 !== vecs[i].fmt32) begin n_err++; $display("FAIL dec%0d_fmt32: got %0d want %0d", i, out_fmt32, vecs[i].fmt32); end
            n_cmp++; if (out_ill32 !== (vecs[i].fmt32 == 3'd7)) begin n_err++; $display("FAIL dec%0d_ill32: got %b", i, out_ill32); end
            n_cmp++; if (out_tag32 !== 16'(i + 100)) begin n_err++; $display("FAIL dec%0d_tag32: got %h want %h", i, out_tag32, 16'(i + 100)); end
            n_cmp++; if (out_imm64 !== vecs[i].imm64) begin n_err++; $display("FAIL dec%0d_imm64: got %h want %h", i, out_imm64, vecs[i].imm64); end
            n_cmp++; if (out_fmt64 !== vecs[i].fmt64) begin n_err++; $display("FAIL dec%0d_fmt64: got %0d want %0d", i, out_fmt64, vecs[i].fmt64); end
            n_cmp++; if (out_ill64 !== (vecs[i].fmt64 == 3'd7)) begin n_err++; $display("FAIL dec%0d_ill64: got %b", i, out_ill64); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got_tags [3];
        int got = 0;
        bit push_now;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_tag = 16'd1; in_instr = 32'h123452B7;
        @(posedge clk); #1;
        in_tag = 16'd2; in_instr = 32'h00309093;
        n_cmp++; if (out_tag32 !== 16'd1) begin n_err++; $display("FAIL b2b_first: got %h want 1", out_tag32); end
        @(posedge clk); #1;
        in_tag = 16'd3; in_instr = 32'h0000007F;
        n_cmp++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", in_ready32); end
        repeat (2) begin
            @(posedge clk); #1;
            n_cmp++; if (out_tag32 !== 16'd1) begin n_err++; $display("FAIL b2b_hold_tag: got %h want 1", out_tag32); end
            n_cmp++; if (out_imm32 !== 32'h12345000) begin n_err++; $display("FAIL b2b_hold_imm: got %h want 12345000", out_imm32); end
            n_cmp++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL b2b_hold_ready: got %b want 0", in_ready32); end
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            @(negedge clk);
            if (out_valid32 && out_ready) begin
                got_tags[got] = out_tag32;
                got++;
            end
            push_now = in_valid && in_ready32;
            @(posedge clk); #1;
            if (push_now) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 3) begin n_err++; $display("FAIL b2b_count: got %0d entries want 3 (timeout)", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++; if (got_tags[i] !== 16'(i + 1)) begin n_err++; $display("FAIL b2b_order%0d: got %h want %h", i, got_tags[i], 16'(i + 1)); end
        end
        @(posedge clk); #1;
        n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", out_valid32); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_tag = 16'h11; in_instr = 32'hFFF00093;
        @(posedge clk); #1;
        in_tag = 16'h12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b want 0", in_ready32); end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_tag = 16'h99; out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid32); end
        n_cmp++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", in_ready32); end
        n_cmp++; if (out_valid64 !== 1'b0) begin n_err++; $display("FAIL flush_valid64: got %b want 0", out_valid64); end
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL flush_push_ignored: got %b want 0", out_valid32); end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b want 0", out_valid32); end
        @(negedge clk);
        in_valid = 1'b1; in_tag = 16'h13; in_instr = 32'h123452B7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (out_tag32 !== 16'h13) begin n_err++; $display("FAIL flush_resume_tag: got %h want 13", out_tag32); end
        n_cmp++; if (out_imm32 !== 32'h12345000) begin n_err++; $display("FAIL flush_resume_imm: got %h want 12345000", out_imm32); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_tag = 16'h21; in_instr = 32'hFE112E23;
        @(posedge clk); #1;
        in_tag = 16'h22;
        @(posedge clk); #1;
        n_cmp++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL mrst_full: got %b want 0", in_ready32); end
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b want 0", out_valid32); end
        n_cmp++; if (out_imm32 !== 32'h0) begin n_err++; $display("FAIL mrst_imm: got %h want 0", out_imm32); end
        n_cmp++; if (out_fmt32 !== 3'd0) begin n_err++; $display("FAIL mrst_fmt: got %0d want 0", out_fmt32); end
        n_cmp++; if (out_ill32 !== 1'b0) begin n_err++; $display("FAIL mrst_ill: got %b want 0", out_ill32); end
        n_cmp++; if (out_tag32 !== 16'h0) begin n_err++; $display("FAIL mrst_tag: got %h want 0", out_tag32); end
        n_cmp++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b want 1", in_ready32); end
        n_cmp++; if (out_imm64 !== 64'h0) begin n_err++; $display("FAIL mrst_imm64: got %h want 0", out_imm64); end
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid32 !== 1'b0) begin n_err++; $display("FAIL mrst_after: got %b want 0", out_valid32); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (e.g. PC) carried with each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1  module can accept an instruction this cycle.
REQ-008 SHALL have port in_instr  input  32  raw RV32/RV64 instruction word.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband tag, passed through unmodified.
REQ-010 SHALL have port out_valid  output  1  decoded entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-012 SHALL have port out_imm  output  XLEN  sign- or zero-extended immediate.
REQ-013 SHALL have port out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-014 SHALL have port out_illegal  output  1  high when the opcode is unrecognised.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the entry at the head.

Function
REQ-016 SHALL map opcode[6:0] as follows: 0010011/0000011/1100111/1110011/0001111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 (and 0111011/0011011 when XLEN=64, as R/I respectively) -> R/I; all others -> ILL.
REQ-017 SHALL build I = instr[31:20], S = {instr[31:25],instr[11:7]}, B = {instr[31],instr[7],instr[30:25],instr[11:8],0}, U = {instr[31:12],12'h0}, J = {instr[31],instr[19:12],instr[20],instr[30:21],0}, each sign-extended from instr[31] to XLEN.
REQ-018 SHALL, for opcode 0010011 with funct3 001 or 101, output imm = zero-extended shamt (instr[24:20] when XLEN=32, instr[25:20] when XLEN=64), ignoring funct7.
REQ-019 SHALL output imm = 0 for the R and ILL formats; out_illegal = 1 only for ILL.
REQ-020 SHALL buffer decoded results in a 2-entry FIFO; an input transfer occurs when in_valid & in_ready, an output transfer when out_valid & out_ready.
REQ-021 SHALL assert in_ready = (count != 2), where count is the number of held entries.
REQ-022 SHALL have a latency of exactly 1 cycle: an entry accepted at edge N is visible on out_* after edge N, with no combinational input-to-output bypass.
REQ-023 SHALL, on a simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-024 SHALL hold out_* stable while out_valid & !out_ready.
REQ-025 SHALL, when flush = 1, set count to 0 at the next edge and ignore any push or pop in that cycle.
REQ-026 SHALL give flush priority over in_valid; a flush with count = 0 has no effect.

Reset
REQ-027 SHALL, while rst_n = 0 at an edge, set count = 0 and drive out_valid = 0, out_imm = 0, out_fmt = 0, out_illegal = 0 and out_tag = 0.
REQ-028 SHALL discard any input transfers in cycles where rst_n = 0; in_ready reads 1 during reset.
REQ-029 SHALL have reset take priority over flush; an assertion of reset mid-stream drops all entries.

Structure
REQ-030 SHALL place the opcode constants, the format-code typedef (3-bit enum) and the XLEN legality check in the shared package imm_pkg.
REQ-031 SHALL implement format detection and extraction in one combinational sub-module, imm_extract; imm_decode_pipe instantiates it ahead of the FIFO.

Verification
REQ-032 SHALL, with XLEN=32, give 0xFFF00093 -> out_imm 0xFFFFFFFF, fmt I; 0xFE112E23 -> 0xFFFFFFFC, fmt S, each with out_valid one cycle after acceptance.
REQ-033 SHALL give 0xFE209CE3 (bne -8) -> out_imm 0xFFFFFFF8, fmt B; 0x123452B7 -> 0x12345000, fmt U.
REQ-034 SHALL give 0x00309093 -> out_imm 3 and 0x4050D093 (srai 5) -> out_imm 5, not 0x405; 0x0000007F -> fmt 7, illegal 1, imm 0.
REQ-035 SHALL, with XLEN=64, give 0x800002B7 -> out_imm 0xFFFFFFFF80000000, and give an srai with shamt 0x25 -> out_imm 0x25.
REQ-036 SHALL, with out_ready = 0 and three back-to-back pushes tagged 1,2,3, accept 1 and 2, deassert in_ready and hold 3; after out_ready = 1, deliver tags in order 1,2,3 with no loss.
REQ-037 SHALL, with count = 2, on flush give out_valid = 0 and in_ready = 1 next cycle; on rst_n low mid-stream, give all outputs at their reset values after the edge.
